obstacle_field: RTL and testbench
=================================

# obstacle_field

Parametrised obstacle generator and pixel renderer for the runner game. It holds N_OBJ scrolling rectangles (cacti), moves them left once per frame on the animate strobe, and respawns retired obstacles off the right edge with LFSR-randomised gap and height. For each pixel strobe it reports whether the current pixel is covered, with a registered colour output. It sits between `vga640x480` (x/y/animate/pixel strobe) and the top-level colour mux.

## Interface
- `N_OBJ`, 3: number of obstacle channels (1–8).
- `COORD_W`, 12: position width. Unsigned.
- `SCREEN_W`, 640: right-edge spawn base.
- `GROUND_Y`, 400: bottom row of obstacles. Exclusive.
- `OBJ_W`, 16: obstacle width.
- `OBJ_H`, 32: tall height. Short height is OBJ_H/2.
- `SPACING`, 240: initial stride between obstacles at reset.
- `MIN_GAP`, 160: minimum respawn distance behind the rightmost active obstacle.
- `SPEED_W`, 4: speed input width.
- `COLOR`, 8'b000_111_00: RGB332 obstacle colour.
- `LFSR_SEED`, 16'hACE1: non-zero LFSR seed.
- `i_clk` in 1: system clock (100 MHz).
- `i_rst` in 1: synchronous, active-high reset.
- `i_pix_stb` in 1: pixel strobe. Samples i_x/i_y.
- `i_animate` in 1: one-cycle end-of-frame strobe.
- `i_enable` in 1: motion enable. Low freezes positions and LFSR.
- `i_speed` in SPEED_W: pixels moved per animate.
- `i_x` in 10: current pixel x.
- `i_y` in 9: current pixel y.
- `o_pix_on` out 1: registered. Pixel is covered by any active obstacle.
- `o_color` out 8: registered. COLOR when o_pix_on, else 0.
- `o_spawn_cnt` out 16: respawn count. Wraps at 2^16.

## Operation
- Per-object state: `x[k]` (COORD_W bits), `tall[k]`, `active[k]`. Global state: 16-bit Galois LFSR, right shift, tap mask 16'hB400.
- Reset values:
  - `x[k] = SCREEN_W + k*SPACING`; `tall[k] = 1`; `active[k] = 1`.
  - LFSR = LFSR_SEED; o_pix_on = 0; o_color = 0; o_spawn_cnt = 0.
- Motion happens on a cycle with i_animate & i_enable & !i_rst.
  - Each active k with `x[k] > i_speed`: `x[k] -= i_speed`.
  - Each active k with `x[k] <= i_speed`: retires and `active[k] = 0`. Never wraps below 0.
  - i_speed = 0: no movement and no retirement.
- Respawn: at most one per animate, processed in the same cycle as motion.
  - Candidate is the lowest-index inactive object. This includes objects retiring in this cycle.
  - `rightmost` = max post-move x over the other active objects, or 0 if none are active.
  - `x = max(SCREEN_W, rightmost + MIN_GAP) + LFSR[6:0]`, using the LFSR value before it advances.
  - `tall = LFSR[7]`; `active = 1`.
  - The LFSR advances one step and o_spawn_cnt increments.
  - Remaining inactive objects wait for later animates, in ascending index order.
- Hit test: on i_pix_stb, for each active k, compute `x[k] <= i_x < x[k]+OBJ_W` and `GROUND_Y - h[k] <= i_y < GROUND_Y`, where h = OBJ_H if tall, else OBJ_H/2.
  - i_x and i_y are zero-extended to COORD_W.
  - o_pix_on = OR over k.
  - o_pix_on and o_color hold their values between strobes.
- Arithmetic: all sums are computed in COORD_W+1 bits. A respawn x above 2^COORD_W−1 saturates to all-ones. Elaboration check: SCREEN_W + N_OBJ*SPACING + 127 < 2^COORD_W.
- i_enable low: positions, active flags and LFSR are frozen. The hit test still runs.

## Timing
- Hit test latency: o_pix_on/o_color are valid on the clock edge after the i_pix_stb cycle, and stable until the next strobe.
- i_animate and i_pix_stb in the same cycle: the hit test uses pre-move positions, and the move applies at that edge.
- Motion, retirement and respawn all complete in the single animate cycle. New x is visible to the next pixel strobe.
- i_rst mid-operation: at the next edge all state returns to reset values. i_rst overrides a simultaneous i_animate or i_pix_stb.
- i_animate held high for multiple cycles: each high cycle is a separate animate. Upstream guarantees a one-cycle pulse.

## Test plan
- **Reset:** i_rst for 2 cycles, then query pixel (639,390) → o_pix_on=0, o_color=0. Internal x = {640, 880, 1120}; o_spawn_cnt=0.
- **Scroll:** 10 animates at speed 4 → x0=600. Pixel (600,368) → on, o_color=8'h1C. Pixels (616,368), (600,400) and (600,367) → off.
- **Retire/respawn:** 160 animates at speed 4. On the 160th, obj0 goes from 4 to retire, obj1=240, obj2=480. Obj0 respawns at 640+LFSR_SEED[6:0] = 640+97 = 737, with tall = LFSR_SEED[7] = 1. o_spawn_cnt=1, and the LFSR steps to 16'hE270.
- **Freeze:** i_enable=0 for 5 animates, then i_speed=0 with enable=1 for 5 animates → positions, LFSR and o_spawn_cnt are unchanged in both phases.
- **Simultaneous retire:** SPACING=0, speed 4, 160 animates → all three retire in the same frame. Obj0 respawns on that frame, obj1 on the next, obj2 on the one after. o_spawn_cnt goes 1, 2, 3, and each new x is at least the previous respawn x + MIN_GAP − 4.
- **Reset collision:** i_rst, i_animate and i_pix_stb all high in one cycle on a covered pixel → next cycle o_pix_on=0 and positions return to reset values.

Source files
------------

// File: rtl/obstacle_field.sv
// obstacle_field: N_OBJ scrolling rectangles with LFSR-randomised respawn and
// a registered per-pixel coverage test feeding the colour mux.
module obstacle_field #(
    parameter int          N_OBJ     = 3,
    parameter int          COORD_W   = 12,
    parameter int          SCREEN_W  = 640,
    parameter int          GROUND_Y  = 400,
    parameter int          OBJ_W     = 16,
    parameter int          OBJ_H     = 32,
    parameter int          SPACING   = 240,
    parameter int          MIN_GAP   = 160,
    parameter int          SPEED_W   = 4,
    parameter logic [7:0]  COLOR     = 8'b000_111_00,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    input  logic               i_animate,
    input  logic               i_enable,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [9:0]         i_x,
    input  logic [8:0]         i_y,
    output logic               o_pix_on,
    output logic [7:0]         o_color,
    output logic [15:0]        o_spawn_cnt
);

    // One spare bit so every sum can be checked for overflow before use.
    localparam int          SW        = COORD_W + 1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    generate
        if (N_OBJ < 1 || N_OBJ > 8) begin : g_bad_nobj
            $error("obstacle_field: N_OBJ must be 1..8");
        end
        if (SCREEN_W + N_OBJ * SPACING + 127 >= (1 << COORD_W)) begin : g_bad_coord
            $error("obstacle_field: reset/spawn positions overflow COORD_W");
        end
    endgenerate

    logic [COORD_W-1:0] x_q [N_OBJ];
    logic [COORD_W-1:0] x_d [N_OBJ];
    logic [N_OBJ-1:0]   tall_q, tall_d;
    logic [N_OBJ-1:0]   active_q, active_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        spawn_cnt_q, spawn_cnt_d;
    logic               pix_on_q, pix_on_d;
    logic [7:0]         color_q, color_d;

    logic [COORD_W-1:0] speed_c;
    logic [N_OBJ-1:0]   spawn_sel;
    logic               spawn_any;
    logic [COORD_W-1:0] rightmost;
    logic [SW-1:0]      gap_sum, spawn_base, spawn_sum;
    logic [COORD_W-1:0] spawn_x;
    logic               hit_any;
    logic [SW-1:0]      xe, ix, iy, y_top;

    assign speed_c = COORD_W'(i_speed);

    // Frame update: move/retire active objects, then respawn the lowest inactive one.
    always_comb begin
        x_d         = x_q;
        tall_d      = tall_q;
        active_d    = active_q;
        lfsr_d      = lfsr_q;
        spawn_cnt_d = spawn_cnt_q;
        spawn_sel   = '0;
        spawn_any   = 1'b0;
        rightmost   = '0;
        gap_sum     = '0;
        spawn_base  = '0;
        spawn_sum   = '0;
        spawn_x     = '0;
        if (i_animate && i_enable) begin
            // Speed zero means a paused frame: nothing moves and nothing retires.
            for (int k = 0; k < N_OBJ; k++) begin
                if (active_q[k] && speed_c != '0) begin
                    if (x_q[k] > speed_c) x_d[k] = x_q[k] - speed_c;
                    else                  active_d[k] = 1'b0;
                end
            end
            // One-hot pick of the lowest-index inactive object (retirees included).
            for (int k = 0; k < N_OBJ; k++) begin
                if (!active_d[k] && !spawn_any) begin
                    spawn_sel[k] = 1'b1;
                    spawn_any    = 1'b1;
                end
            end
            // The candidate is inactive, so it never contributes to rightmost.
            for (int k = 0; k < N_OBJ; k++) begin
                if (active_d[k] && x_d[k] > rightmost) rightmost = x_d[k];
            end
            gap_sum    = {1'b0, rightmost} + SW'(MIN_GAP);
            spawn_base = (gap_sum > SW'(SCREEN_W)) ? gap_sum : SW'(SCREEN_W);
            spawn_sum  = spawn_base + SW'(lfsr_q[6:0]);
            spawn_x    = spawn_sum[COORD_W] ? {COORD_W{1'b1}} : spawn_sum[COORD_W-1:0];
            if (spawn_any) begin
                for (int k = 0; k < N_OBJ; k++) begin
                    if (spawn_sel[k]) begin
                        x_d[k]      = spawn_x;
                        tall_d[k]   = lfsr_q[7];
                        active_d[k] = 1'b1;
                    end
                end
                lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
                spawn_cnt_d = spawn_cnt_q + 16'd1;
            end
        end
    end

    // Pixel coverage test against the current (pre-move) positions.
    always_comb begin
        hit_any = 1'b0;
        xe      = '0;
        y_top   = '0;
        ix      = SW'(i_x);
        iy      = SW'(i_y);
        for (int k = 0; k < N_OBJ; k++) begin
            xe    = {1'b0, x_q[k]};
            y_top = tall_q[k] ? SW'(GROUND_Y - OBJ_H) : SW'(GROUND_Y - OBJ_H / 2);
            if (active_q[k] && ix >= xe && ix < xe + SW'(OBJ_W) &&
                iy >= y_top && iy < SW'(GROUND_Y)) begin
                hit_any = 1'b1;
            end
        end
        pix_on_d = i_pix_stb ? hit_any : pix_on_q;
        color_d  = pix_on_d ? COLOR : 8'h00;
    end

    // State registers; reset wins over any simultaneous strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_OBJ; k++) begin
                x_q[k] <= COORD_W'(SCREEN_W + k * SPACING);
            end
            tall_q      <= '1;
            active_q    <= '1;
            lfsr_q      <= LFSR_SEED;
            spawn_cnt_q <= '0;
            pix_on_q    <= 1'b0;
            color_q     <= 8'h00;
        end else begin
            x_q         <= x_d;
            tall_q      <= tall_d;
            active_q    <= active_d;
            lfsr_q      <= lfsr_d;
            spawn_cnt_q <= spawn_cnt_d;
            pix_on_q    <= pix_on_d;
            color_q     <= color_d;
        end
    end

    assign o_pix_on    = pix_on_q;
    assign o_color     = color_q;
    assign o_spawn_cnt = spawn_cnt_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Bench for obstacle_field: two instances (default spacing and zero spacing)
// driven in lockstep and checked against an arithmetic model of the game rules.
module tb_obstacle_field;

    localparam int N = 3;

    logic       i_clk = 1'b0;
    logic       i_rst, i_pix_stb, i_animate, i_enable;
    logic [3:0] i_speed;
    logic [9:0] i_x;
    logic [8:0] i_y;
    logic       pa, pb;
    logic [7:0] ca, cb;
    logic [15:0] sa, sb;

    always #5 i_clk = ~i_clk;

    obstacle_field dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_animate(i_animate),
        .i_enable(i_enable), .i_speed(i_speed), .i_x(i_x), .i_y(i_y),
        .o_pix_on(pa), .o_color(ca), .o_spawn_cnt(sa)
    );

    obstacle_field #(.SPACING(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_animate(i_animate),
        .i_enable(i_enable), .i_speed(i_speed), .i_x(i_x), .i_y(i_y),
        .o_pix_on(pb), .o_color(cb), .o_spawn_cnt(sb)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, [unit][object].
    int mx [2][N];
    bit ma [2][N];
    bit mt [2][N];
    int mlfsr [2];
    int mcnt [2];
    bit mpix [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < N; k++) begin
                mx[u][k] = 640 + k * ((u == 0) ? 240 : 0);
                ma[u][k] = 1'b1;
                mt[u][k] = 1'b1;
            end
            mlfsr[u] = 'hACE1;
            mcnt[u]  = 0;
            mpix[u]  = 1'b0;
        end
    endtask

    function automatic bit model_hit(input int u, input int px, input int py);
        int h;
        for (int k = 0; k < N; k++) begin
            h = mt[u][k] ? 32 : 16;
            if (ma[u][k] && px >= mx[u][k] && px < mx[u][k] + 16 && py >= 400 - h && py < 400)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_animate(input int u, input int s);
        int c, rm, nx;
        for (int k = 0; k < N; k++) begin
            if (ma[u][k] && s != 0) begin
                if (mx[u][k] > s) mx[u][k] -= s;
                else              ma[u][k] = 1'b0;
            end
        end
        c = -1;
        for (int k = N - 1; k >= 0; k--) if (!ma[u][k]) c = k;
        if (c < 0) return;
        rm = 0;
        for (int k = 0; k < N; k++) if (k != c && ma[u][k] && mx[u][k] > rm) rm = mx[u][k];
        nx = ((rm + 160 > 640) ? rm + 160 : 640) + (mlfsr[u] % 128);
        if (nx > 4095) nx = 4095;
        mx[u][c] = nx;
        mt[u][c] = bit'((mlfsr[u] / 128) % 2);
        ma[u][c] = 1'b1;
        mlfsr[u] = (mlfsr[u] / 2) ^ ((mlfsr[u] % 2 == 1) ? 'hB400 : 0);
        mcnt[u]  = (mcnt[u] + 1) % 65536;
    endtask

    // Drive one cycle; the model advances at the same edge as the DUT.
    task automatic tick(input bit rst, input bit anim, input bit stb, input int px, input int py);
        i_rst     = rst;
        i_animate = anim;
        i_pix_stb = stb;
        i_x       = 10'(px);
        i_y       = 9'(py);
        @(posedge i_clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (stb) mpix[u] = model_hit(u, px % 1024, py % 512);
                if (anim && i_enable) model_animate(u, int'(i_speed));
            end
        end
        #1;
        i_rst     = 1'b0;
        i_animate = 1'b0;
        i_pix_stb = 1'b0;
    endtask

    function automatic logic [31:0] obs_x(input int u, input int k);
        return (u == 0) ? 32'(dut_a.x_q[k]) : 32'(dut_b.x_q[k]);
    endfunction

    task automatic chk_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("%s_x%0d_u%0d", tag, k, u), obs_x(u, k), 32'(mx[u][k]));
                chk($sformatf("%s_act%0d_u%0d", tag, k, u),
                    (u == 0) ? 32'(dut_a.active_q[k]) : 32'(dut_b.active_q[k]), 32'(ma[u][k]));
                chk($sformatf("%s_tall%0d_u%0d", tag, k, u),
                    (u == 0) ? 32'(dut_a.tall_q[k]) : 32'(dut_b.tall_q[k]), 32'(mt[u][k]));
            end
            chk($sformatf("%s_lfsr_u%0d", tag, u),
                (u == 0) ? 32'(dut_a.lfsr_q) : 32'(dut_b.lfsr_q), 32'(mlfsr[u]));
            chk($sformatf("%s_cnt_u%0d", tag, u), (u == 0) ? 32'(sa) : 32'(sb), 32'(mcnt[u]));
        end
    endtask

    task automatic chk_pix(input string tag);
        chk({tag, "_on_a"},  32'(pa), 32'(mpix[0]));
        chk({tag, "_col_a"}, 32'(ca), mpix[0] ? 32'h1C : 32'h0);
        chk({tag, "_on_b"},  32'(pb), 32'(mpix[1]));
        chk({tag, "_col_b"}, 32'(cb), mpix[1] ? 32'h1C : 32'h0);
    endtask

    initial begin
        int px, py, kk;
        bit anim, stb;
        logic [31:0] prev_x;

        i_rst = 1'b1; i_animate = 1'b0; i_pix_stb = 1'b0;
        i_enable = 1'b1; i_speed = 4'd4; i_x = '0; i_y = '0;
        model_reset();

        // Reset state
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk_state("reset");
        chk("reset_x1_const", obs_x(0, 1), 32'd880);
        chk("reset_x2_const", obs_x(0, 2), 32'd1120);
        tick(0, 0, 1, 639, 390);
        chk_pix("reset_pix");

        // Scroll ten frames at speed 4
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
        chk("scroll_x0_const", obs_x(0, 0), 32'd600);
        chk_state("scroll");
        tick(0, 0, 1, 600, 368);
        chk("scroll_on_const", 32'(pa), 32'd1);
        chk_pix("pix_600_368");
        tick(0, 0, 0, 0, 0);
        chk_pix("pix_hold");
        tick(0, 0, 1, 616, 368);
        chk_pix("pix_616_368");
        tick(0, 0, 1, 600, 400);
        chk_pix("pix_600_400");
        tick(0, 0, 1, 600, 367);
        chk_pix("pix_600_367");

        // Retire and respawn on frame 160
        for (int i = 0; i < 150; i++) tick(0, 1, 0, 0, 0);
        chk("respawn_x0_const", obs_x(0, 0), 32'd737);
        chk("respawn_x1_const", obs_x(0, 1), 32'd240);
        chk("respawn_x2_const", obs_x(0, 2), 32'd480);
        chk("respawn_tall_const", 32'(dut_a.tall_q[0]), 32'd1);
        chk("respawn_cnt_const", 32'(sa), 32'd1);
        chk("respawn_lfsr_const", 32'(dut_a.lfsr_q), 32'hE270);
        chk_state("respawn");

        // Simultaneous retirement in the zero-spacing instance drains one per frame
        chk("simul_cnt1", 32'(sb), 32'd1);
        prev_x = obs_x(1, 0);
        tick(0, 1, 0, 0, 0);
        chk("simul_cnt2", 32'(sb), 32'd2);
        chk("simul_gap1", 32'(obs_x(1, 1) >= prev_x + 156), 32'd1);
        prev_x = obs_x(1, 1);
        tick(0, 1, 0, 0, 0);
        chk("simul_cnt3", 32'(sb), 32'd3);
        chk("simul_gap2", 32'(obs_x(1, 2) >= prev_x + 156), 32'd1);
        chk_state("simul");

        // Freeze: enable low, then speed zero
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
        chk_state("freeze_en");
        i_enable = 1'b1; i_speed = 4'd0;
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 0, 0);
        chk_state("freeze_spd");

        // Randomised play, pixels aimed near obstacles
        for (int c = 0; c < 3000; c++) begin
            i_enable = ($urandom_range(0, 9) != 0);
            i_speed  = 4'($urandom_range(0, 15));
            anim     = ($urandom_range(0, 3) == 0);
            stb      = ($urandom_range(0, 1) == 0);
            kk       = $urandom_range(0, N - 1);
            px       = mx[0][kk] + int'($urandom_range(0, 24)) - 4;
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            py       = $urandom_range(360, 405);
            tick(0, anim, stb, px, py);
            chk_pix("rand_pix");
            if (c % 100 == 99) chk_state("rand");
        end
        chk_state("rand_end");

        // Reset colliding with animate and a covered pixel
        i_enable = 1'b1; i_speed = 4'd4;
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 600, 390);
        chk("coll_pre_on", 32'(pa), 32'd1);
        chk_pix("coll_pre");
        tick(1, 1, 1, 600, 390);
        chk("coll_on_const", 32'(pa), 32'd0);
        chk("coll_x0_const", obs_x(0, 0), 32'd640);
        chk_pix("coll_post");
        chk_state("coll");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
